// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: control-transfer opcode
// encoding, FSM state encoding, PC arithmetic constants and small decode
// helpers used by both the top level and the condition evaluator.
package branch_resolve_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLEZ = 4'd3,
    OP_BGTZ = 4'd4,
    OP_BLTZ = 4'd5,
    OP_BGEZ = 4'd6,
    OP_J    = 4'd7,
    OP_JAL  = 4'd8,
    OP_JR   = 4'd9,
    OP_JALR = 4'd10
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SLOT = 2'd2
  } state_e;

  localparam logic [31:0] PC_INCR     = 32'd4;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  function automatic logic needs_rs(br_op_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
                      OP_JR, OP_JALR};
  endfunction

  function automatic logic needs_rt(br_op_e op);
    return op inside {OP_BEQ, OP_BNE};
  endfunction

  function automatic logic is_jump(br_op_e op);
    return op inside {OP_J, OP_JAL, OP_JR, OP_JALR};
  endfunction

  function automatic logic is_link(br_op_e op);
    return op inside {OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   br_op  - control-transfer code (br_op_e encoding)
//   rs_val - first operand, two's complement
//   rt_val - second operand, two's complement
//   taken  - 1 when a B-type condition holds; always 0 for jumps and NONE
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [3:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    taken = 1'b0;
    case (br_op_e'(br_op))
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = ($signed(rs_val) <= 0);
      OP_BGTZ: taken = ($signed(rs_val) >  0);
      OP_BLTZ: taken = ($signed(rs_val) <  0);
      OP_BGEZ: taken = ($signed(rs_val) >= 0);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves ID-stage control transfers, stalls the PC
// while a needed operand is pending, and presents the resolved branch/jump
// for exactly one delay-slot cycle.
// Ports:
//   clk, reset           - clock; synchronous active-low reset
//   id_valid, id_pc      - ID-stage instruction valid and its PC
//   br_op                - control-transfer code
//   rs_val/rt_val        - operand values; rs_ready/rt_ready operand valid
//   imm16, jindex        - branch offset and jump index
//   branch, jump         - registered PC-source selects (SLOT cycle only)
//   ta, jump_target      - registered branch and jump targets
//   pc_le, npc_le        - combinational PC/NPC load enables (0 = stall)
//   link_we, link_addr   - return-address write for JAL/JALR
//   slot_err             - control transfer seen in the delay slot
//   stall_cycles         - saturating count of cycles spent in WAIT
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter bit RESET_PC_LE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [3:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic [15:0] imm16,
  input  logic [25:0] jindex,
  output logic        branch,
  output logic        jump,
  output logic [31:0] ta,
  output logic [31:0] jump_target,
  output logic        pc_le,
  output logic        npc_le,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        slot_err,
  output logic [15:0] stall_cycles
);

  state_e      state_q, state_d;
  logic        branch_q, jump_q, link_we_q, slot_err_q;
  logic [31:0] ta_q, jump_target_q, link_addr_q;
  logic [15:0] stall_q;

  br_op_e      op;
  logic        cti;
  logic        ops_ready;
  logic        stall_hold;
  logic        load;
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] ta_calc;
  logic [31:0] jt_calc;

  // id_valid=0 is indistinguishable from NONE everywhere below.
  assign op        = br_op_e'(br_op);
  assign cti       = id_valid && (op != OP_NONE);
  assign ops_ready = (!needs_rs(op) || rs_ready) && (!needs_rt(op) || rt_ready);

  branch_cond_eval u_cond (
    .br_op  (br_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .taken  (taken)
  );

  assign pc_plus4 = id_pc + PC_INCR;
  assign ta_calc  = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    jt_calc = '0;
    case (op)
      OP_J, OP_JAL:   jt_calc = {pc_plus4[31:28], jindex, 2'b00};
      OP_JR, OP_JALR: jt_calc = rs_val;
      default:        jt_calc = '0;
    endcase
  end

  // Next state and stall decision. A CTI arriving during SLOT is never
  // considered here: it only raises slot_err.
  always_comb begin
    state_d    = state_q;
    stall_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cti) begin
          state_d    = ops_ready ? ST_SLOT : ST_WAIT;
          stall_hold = !ops_ready;
        end
      end
      ST_WAIT: begin
        if (!cti) begin
          state_d = ST_IDLE;          // transfer withdrawn upstream
        end else if (!ops_ready) begin
          stall_hold = 1'b1;
        end else begin
          state_d = ST_SLOT;
        end
      end
      ST_SLOT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign load   = (state_d == ST_SLOT) && (state_q != ST_SLOT);
  assign pc_le  = reset ? !stall_hold : RESET_PC_LE;
  assign npc_le = pc_le;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      ta_q          <= '0;
      jump_target_q <= '0;
      link_we_q     <= 1'b0;
      link_addr_q   <= '0;
      slot_err_q    <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      // Resolved outputs live for the SLOT cycle only; otherwise cleared.
      branch_q      <= load && !is_jump(op) && taken;
      jump_q        <= load && is_jump(op);
      ta_q          <= load ? ta_calc : '0;
      jump_target_q <= load ? jt_calc : '0;
      link_we_q     <= load && is_link(op);
      link_addr_q   <= (load && is_link(op)) ? (id_pc + LINK_OFFSET) : '0;
      slot_err_q    <= (state_q == ST_SLOT) && cti;
      if ((state_q == ST_WAIT) && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign branch       = branch_q;
  assign jump         = jump_q;
  assign ta           = ta_q;
  assign jump_target  = jump_target_q;
  assign link_we      = link_we_q;
  assign link_addr    = link_addr_q;
  assign slot_err     = slot_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table,
// randomized transactions against a transaction-level model, and hand
// sequences for reset, saturation and abandoned transfers.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [3:0]  br_op;
  logic [31:0] rs_val, rt_val;
  logic        rs_ready, rt_ready;
  logic [15:0] imm16;
  logic [25:0] jindex;
  logic        branch, jump, pc_le, npc_le, link_we, slot_err;
  logic [31:0] ta, jump_target, link_addr;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  branch_resolve_unit #(.RESET_PC_LE(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .br_op        (br_op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .rs_ready     (rs_ready),
    .rt_ready     (rt_ready),
    .imm16        (imm16),
    .jindex       (jindex),
    .branch       (branch),
    .jump         (jump),
    .ta           (ta),
    .jump_target  (jump_target),
    .pc_le        (pc_le),
    .npc_le       (npc_le),
    .link_we      (link_we),
    .link_addr    (link_addr),
    .slot_err     (slot_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc, rs, rt;
    logic [15:0] imm;
    logic [25:0] jidx;
    int          k;          // cycles the needed operand stays not ready
    logic        slot_valid;
    logic [3:0]  slot_op;
    logic        e_br, e_jmp;
    logic [31:0] e_ta, e_jt;
    logic        e_lwe;
    logic [31:0] e_la;
    logic        e_serr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic m_needs_rs(logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd6) || op == 4'd9 || op == 4'd10;
  endfunction

  function automatic logic m_needs_rt(logic [3:0] op);
    return op == 4'd1 || op == 4'd2;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   off;
    logic t;
    case (v.op)
      4'd1:    t = (v.rs == v.rt);
      4'd2:    t = (v.rs != v.rt);
      4'd3:    t = ($signed(v.rs) <= 0);
      4'd4:    t = ($signed(v.rs) > 0);
      4'd5:    t = ($signed(v.rs) < 0);
      4'd6:    t = ($signed(v.rs) >= 0);
      default: t = 1'b0;
    endcase
    off     = $signed(v.imm);
    r.e_br  = t;
    r.e_jmp = (v.op >= 4'd7);
    r.e_ta  = v.pc + 32'd4 + 32'(off * 4);
    if (v.op == 4'd7 || v.op == 4'd8)
      r.e_jt = ((v.pc + 32'd4) & 32'hF000_0000) | (32'(v.jidx) * 32'd4);
    else if (v.op == 4'd9 || v.op == 4'd10)
      r.e_jt = v.rs;
    else
      r.e_jt = 32'd0;
    r.e_lwe  = (v.op == 4'd8 || v.op == 4'd10);
    r.e_la   = r.e_lwe ? v.pc + 32'd8 : 32'd0;
    r.e_serr = v.slot_valid && (v.slot_op != 4'd0);
    return r;
  endfunction

  // Drives one control transfer from IDLE through its delay slot.
  task automatic run_vec(input vec_t v, input string tag);
    id_valid = 1'b1; br_op = v.op; id_pc = v.pc; rs_val = v.rs; rt_val = v.rt;
    imm16 = v.imm; jindex = v.jidx; rs_ready = 1'b1; rt_ready = 1'b1;
    if (v.k > 0) begin
      if (m_needs_rt(v.op) && ($urandom_range(0, 1) == 1)) rt_ready = 1'b0;
      else rs_ready = 1'b0;
    end
    for (int i = 0; i < v.k; i++) begin
      #1;
      check({tag, " stall pc_le"}, 32'(pc_le), 32'd0);
      check({tag, " stall npc_le"}, 32'(npc_le), 32'd0);
      @(posedge clk); #1;
    end
    rs_ready = 1'b1; rt_ready = 1'b1;
    #1;
    check({tag, " resolve pc_le"}, 32'(pc_le), 32'd1);
    @(posedge clk); #1;
    exp_stall = (exp_stall + v.k > 65535) ? 65535 : exp_stall + v.k;
    check({tag, " branch"}, 32'(branch), 32'(v.e_br));
    check({tag, " jump"}, 32'(jump), 32'(v.e_jmp));
    check({tag, " ta"}, ta, v.e_ta);
    check({tag, " jump_target"}, jump_target, v.e_jt);
    check({tag, " link_we"}, 32'(link_we), 32'(v.e_lwe));
    check({tag, " link_addr"}, link_addr, v.e_la);
    id_valid = v.slot_valid; br_op = v.slot_op;
    #1;
    check({tag, " slot pc_le"}, 32'(pc_le), 32'd1);
    @(posedge clk); #1;
    check({tag, " post-slot branch"}, 32'(branch), 32'd0);
    check({tag, " post-slot jump"}, 32'(jump), 32'd0);
    check({tag, " slot_err"}, 32'(slot_err), 32'(v.e_serr));
    check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    id_valid = 1'b0; br_op = 4'd0;
    @(posedge clk); #1;
    check({tag, " slot_err clears"}, 32'(slot_err), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    // op pc rs rt imm jidx k sv sop | br jmp ta jt lwe la serr
    tbl[0]  = '{4'd1, 32'h100, 32'd5, 32'd5, 16'h0003, 26'd0, 0, 1'b0, 4'd0,
                1'b1, 1'b0, 32'h110, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{4'd2, 32'h200, 32'd1, 32'd1, 16'h0010, 26'd0, 0, 1'b0, 4'd0,
                1'b0, 1'b0, 32'h244, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[2]  = '{4'd4, 32'h40, 32'd7, 32'd0, 16'hFFFF, 26'd0, 3, 1'b0, 4'd0,
                1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{4'd8, 32'h1000_0000, 32'd0, 32'd0, 16'h0000, 26'h0000010, 0, 1'b0, 4'd0,
                1'b0, 1'b1, 32'h1000_0004, 32'h1000_0040, 1'b1, 32'h1000_0008, 1'b0};
    tbl[4]  = '{4'd1, 32'h500, 32'd9, 32'd9, 16'h0002, 26'd0, 0, 1'b1, 4'd9,
                1'b1, 1'b0, 32'h50C, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[5]  = '{4'd5, 32'h300, 32'h8000_0000, 32'd0, 16'h8000, 26'd0, 0, 1'b0, 4'd0,
                1'b1, 1'b0, 32'hFFFE_0304, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[6]  = '{4'd6, 32'h600, 32'd0, 32'd0, 16'h0001, 26'd0, 0, 1'b0, 4'd0,
                1'b1, 1'b0, 32'h608, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[7]  = '{4'd3, 32'h700, 32'd1, 32'd0, 16'h0001, 26'd0, 0, 1'b0, 4'd0,
                1'b0, 1'b0, 32'h708, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[8]  = '{4'd10, 32'hFFFF_FFF8, 32'h1234, 32'd0, 16'h0000, 26'd0, 1, 1'b0, 4'd0,
                1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b1, 32'h0, 1'b0};
    tbl[9]  = '{4'd9, 32'h800, 32'hABCD_0000, 32'd0, 16'h0000, 26'd0, 2, 1'b0, 4'd0,
                1'b0, 1'b1, 32'h804, 32'hABCD_0000, 1'b0, 32'h0, 1'b0};
    tbl[10] = '{4'd7, 32'hF000_0010, 32'd0, 32'd0, 16'h0000, 26'h3FF_FFFF, 0, 1'b0, 4'd0,
                1'b0, 1'b1, 32'hF000_0014, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0};
    tbl[11] = '{4'd3, 32'h0, 32'hFFFF_FFFF, 32'd0, 16'h0000, 26'd0, 0, 1'b0, 4'd1,
                1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0};

    // Reset with a stalling CTI presented: load enables follow RESET_PC_LE.
    reset = 1'b0; id_valid = 1'b1; br_op = 4'd1; id_pc = 32'h0; rs_val = 32'd0;
    rt_val = 32'd0; rs_ready = 1'b0; rt_ready = 1'b0; imm16 = 16'd0; jindex = 26'd0;
    #1;
    check("reset pc_le", 32'(pc_le), 32'd1);
    check("reset npc_le", 32'(npc_le), 32'd1);
    @(posedge clk); #1;
    check("reset branch", 32'(branch), 32'd0);
    check("reset jump", 32'(jump), 32'd0);
    check("reset ta", ta, 32'd0);
    check("reset jump_target", jump_target, 32'd0);
    check("reset link", {31'd0, link_we} | link_addr, 32'd0);
    check("reset slot_err", 32'(slot_err), 32'd0);
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
    id_valid = 1'b0; br_op = 4'd0; rs_ready = 1'b1; rt_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.op   = 4'($urandom_range(1, 10));
      v.pc   = $urandom() & 32'hFFFF_FFFC;
      v.rs   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom();
      v.rt   = ($urandom_range(0, 1) == 0) ? v.rs : $urandom();
      v.imm  = 16'($urandom());
      v.jidx = 26'($urandom());
      v.k    = m_needs_rs(v.op) ? $urandom_range(0, 3) : 0;
      v.slot_valid = 1'($urandom_range(0, 1));
      v.slot_op    = 4'($urandom_range(0, 10));
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    // JR stuck in WAIT long enough to saturate, then reset abandons it.
    id_valid = 1'b1; br_op = 4'd9; rs_val = 32'hDEAD_BEE0; rs_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    check("sat stall_cycles", 32'(stall_cycles), 32'hFFFF);
    check("sat pc_le", 32'(pc_le), 32'd0);
    reset = 1'b0;
    #1;
    check("wait-reset pc_le", 32'(pc_le), 32'd1);
    @(posedge clk); #1;
    check("wait-reset jump", 32'(jump), 32'd0);
    check("wait-reset jump_target", jump_target, 32'd0);
    check("wait-reset stall_cycles", 32'(stall_cycles), 32'd0);
    id_valid = 1'b0; br_op = 4'd0; rs_ready = 1'b1; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post-reset no jump", 32'(jump), 32'd0);
    end
    exp_stall = 0;

    // Taken BEQ reaches SLOT, then reset during SLOT wipes it.
    id_valid = 1'b1; br_op = 4'd1; id_pc = 32'h900; rs_val = 32'd3; rt_val = 32'd3;
    imm16 = 16'd1; rs_ready = 1'b1; rt_ready = 1'b1;
    @(posedge clk); #1;
    check("slot-reset branch before", 32'(branch), 32'd1);
    id_valid = 1'b0; br_op = 4'd0; reset = 1'b0;
    @(posedge clk); #1;
    check("slot-reset branch", 32'(branch), 32'd0);
    check("slot-reset ta", ta, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("slot-reset after release", 32'(branch), 32'd0);
    check("slot-reset stall_cycles", 32'(stall_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter: RESET_PC_LE, default 1, meaning value of pc_le/npc_le while in reset.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 id_valid  input  1  ID-stage instruction valid.
REQ-005 id_pc  input  32  PC of the ID-stage instruction.
REQ-006 br_op  input  4  control-transfer code: NONE, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J, JAL, JR, JALR.
REQ-007 rs_val, rt_val  input  32 each  operand values, two's complement.
REQ-008 rs_ready, rt_ready  input  1 each  operand valid (no pending hazard).
REQ-009 imm16  input  16  branch offset; jindex  input  26  jump index.
REQ-010 branch, jump  output  1 each  to the PC source selector; ta, jump_target  output  32 each  to the PC mux.
REQ-011 pc_le, npc_le  output  1 each  PC/NPC register load enables.
REQ-012 link_we  output  1; link_addr  output  32  return address for JAL/JALR.
REQ-013 slot_err  output  1  control transfer in delay slot; stall_cycles  output  16  hazard-stall counter.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, SLOT.
REQ-015 Operand needs: BEQ/BNE need rs and rt; BLEZ/BGTZ/BLTZ/BGEZ/JR/JALR need rs; J/JAL/NONE need none.
REQ-016 IDLE: id_valid with br_op!=NONE and needed operands ready -> SLOT; needed operand not ready -> WAIT; otherwise stay IDLE.
REQ-017 WAIT: stay while a needed operand is not ready; -> SLOT in the cycle it becomes ready; inputs are held stable by upstream while in WAIT.
REQ-018 SLOT: lasts exactly one cycle, then -> IDLE unconditionally.
REQ-019 pc_le and npc_le SHALL be combinational: 0 when (IDLE with id_valid, CTI, operand not ready) or (WAIT with operand still not ready); 1 otherwise.
REQ-020 On the IDLE/WAIT->SLOT transition edge the unit SHALL register the outputs: branch=taken condition for B-type, jump=1 for J/JAL/JR/JALR, ta, jump_target, link_we, link_addr; all are held during SLOT only and are 0 in every other state.
REQ-021 Conditions: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0 (signed).
REQ-022 ta = id_pc + 4 + (sign_extend(imm16) << 2), modulo 2^32 (wrap-around allowed, no flag).
REQ-023 jump_target = {(id_pc+4)[31:28], jindex, 2'b00} for J/JAL; rs_val for JR/JALR; 0 for B-type.
REQ-024 link_we=1 and link_addr=id_pc+8 (mod 2^32) for JAL/JALR only; link_addr=0 otherwise.
REQ-025 Not-taken branch SHALL still enter SLOT with branch=0, jump=0 (delay slot executes).
REQ-026 id_valid with br_op!=NONE during SLOT SHALL pulse slot_err for one cycle (registered, visible next cycle), be ignored as a control transfer, and not stall.
REQ-027 stall_cycles SHALL increment by 1 for each cycle spent in WAIT, saturating at 0xFFFF.
REQ-028 id_valid=0 SHALL be treated as br_op=NONE in every state.

Reset
REQ-029 While reset=0 at a clock edge: state=IDLE, branch=jump=link_we=slot_err=0, ta=jump_target=link_addr=0, stall_cycles=0.
REQ-030 pc_le=npc_le=RESET_PC_LE while reset=0, regardless of other inputs.
REQ-031 Reset asserted in WAIT or SLOT SHALL abandon the pending transfer; no branch/jump pulse follows release.

Structure
REQ-032 Shared package SHALL hold the br_op encoding, FSM state enum, and constants PC_INCR=4, LINK_OFFSET=8.
REQ-033 Condition evaluation SHALL be one combinational sub-module branch_cond_eval (inputs br_op, rs_val, rt_val; output taken).

Verification
REQ-034 BEQ id_pc=0x100, rs=rt=5, imm16=0x0003, ready -> next cycle branch=1, ta=0x110, pc_le=1, one cycle only.
REQ-035 BNE id_pc=0x200, rs=1, rt=1 -> SLOT with branch=0, jump=0; then IDLE.
REQ-036 BGTZ rs_ready=0 for 3 cycles then 1, rs=7, imm16=0xFFFF, id_pc=0x40 -> pc_le=npc_le=0 for 3 cycles, stall_cycles=3, branch=1, ta=0x40.
REQ-037 JAL id_pc=0x1000_0000, jindex=0x0000010 -> jump=1, jump_target=0x1000_0040, link_we=1, link_addr=0x1000_0008.
REQ-038 JR in SLOT right after taken BEQ -> slot_err=1 one cycle, jump=0, no stall.
REQ-039 reset=0 during WAIT of a JR -> all outputs 0, pc_le=1; after release no jump pulse, stall_cycles=0.
